// File: rtl/task_pkg.sv
// Shared types, transform selectors and helpers for the task packet engine.
package task_pkg;

  typedef enum logic [1:0] {
    ST_REQUEST = 2'd0,
    ST_PREP    = 2'd1,
    ST_ANSWER  = 2'd2
  } task_state_t;

  localparam int MODE_PASS     = 0;
  localparam int MODE_BYTE_REV = 1;
  localparam int MODE_WORD_REV = 2;
  localparam int MODE_SUM      = 3;

  // Answer length in bytes for a packet of the given word count.
  function automatic logic [31:0] packet_bytes(input logic [31:0] words,
                                               input logic [31:0] bytes_per_word);
    return words * bytes_per_word;
  endfunction

endpackage

// File: rtl/task_packet_buffer.sv
// Packet word store: simple dual-port RAM, one write and one registered read per cycle.
module task_packet_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rd_data_r;

  // Write port and registered read port; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
    rd_data_r <= mem_r[rd_addr];
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/task_packet_engine.sv
// Captures an input packet, then streams a transformed answer packet back
// under a ready/accept handshake.
module task_packet_engine #(
  parameter int DATA_W            = 32,
  parameter int DEPTH             = 16,
  parameter int MODE              = 0,
  parameter int PACKET_SIZE_WIDTH = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  output logic                         o_task_data_request,
  input  logic                         i_task_data_valid,
  input  logic [DATA_W-1:0]            i_task_data,
  input  logic                         i_task_data_last,
  output logic                         o_task_answer_ready,
  output logic [DATA_W-1:0]            o_task_answer_data,
  output logic                         o_task_answer_data_last,
  output logic [PACKET_SIZE_WIDTH-1:0] o_task_answer_packet_size_in_bytes,
  input  logic                         i_task_answer_accept,
  output logic                         o_overflow,
  output logic [15:0]                  o_packets_done
);

  import task_pkg::*;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  task_state_t state_r;
  task_state_t state_s;

  logic [CW-1:0]                count_r;
  logic [CW-1:0]                idx_r;
  logic [CW-1:0]                rd_idx_s;
  logic [CW-1:0]                rd_word_s;
  logic [AW-1:0]                rd_addr_s;
  logic [DATA_W-1:0]            rd_data_s;
  logic                         wr_en_s;
  logic                         ovf_s;
  logic                         accept_s;
  logic                         request_s;
  logic                         ready_r;
  logic                         last_r;
  logic [PACKET_SIZE_WIDTH-1:0] size_r;
  logic                         overflow_r;
  logic [15:0]                  done_r;
  logic [DATA_W-1:0]            sum_r;
  logic [DATA_W-1:0]            xform_s;
  logic [DATA_W-1:0]            answer_data_s;
  logic [31:0]                  bytes_s;

  function automatic logic [DATA_W-1:0] byte_rev(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int b = 0; b < DATA_W / 8; b++) begin
      r[8*b +: 8] = w[DATA_W-8-8*b +: 8];
    end
    return r;
  endfunction

  assign accept_s = ready_r & i_task_answer_accept;
  assign wr_en_s  = (state_r == ST_REQUEST) && i_task_data_valid && (count_r < CW'(DEPTH));
  assign ovf_s    = (state_r == ST_REQUEST) && i_task_data_valid && (count_r == CW'(DEPTH));
  assign bytes_s  = packet_bytes(32'(count_r), 32'(DATA_W / 8));

  task_packet_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_buffer (
    .clk     (i_clk),
    .wr_en   (wr_en_s),
    .wr_addr (count_r[AW-1:0]),
    .wr_data (i_task_data),
    .rd_addr (rd_addr_s),
    .rd_data (rd_data_s)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_r <= ST_REQUEST;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_REQUEST: begin
        if (i_task_data_valid && i_task_data_last) state_s = ST_PREP;
        else                                       state_s = ST_REQUEST;
      end
      ST_PREP:    state_s = ST_ANSWER;
      ST_ANSWER: begin
        if (accept_s && last_r) state_s = ST_REQUEST;
        else                    state_s = ST_ANSWER;
      end
      default:    state_s = ST_REQUEST;
    endcase
  end

  // Read prefetch: the RAM always fetches the word to be shown next cycle,
  // so an accepted word is replaced without a bubble.
  always_comb begin
    rd_idx_s = '0;
    if (state_r == ST_ANSWER) begin
      if (accept_s) rd_idx_s = idx_r + CW'(1);
      else          rd_idx_s = idx_r;
    end else begin
      rd_idx_s = '0;
    end
    if (MODE == MODE_WORD_REV) rd_word_s = count_r - CW'(1) - rd_idx_s;
    else                       rd_word_s = rd_idx_s;
    rd_addr_s = rd_word_s[AW-1:0];
  end

  // Output decode: request flag and transformed, ready-gated answer word.
  always_comb begin
    request_s = (state_r == ST_REQUEST);
    case (MODE)
      MODE_BYTE_REV: xform_s = byte_rev(rd_data_s);
      MODE_SUM:      xform_s = sum_r + rd_data_s;
      default:       xform_s = rd_data_s;
    endcase
    if (ready_r) answer_data_s = xform_s;
    else         answer_data_s = '0;
  end

  // Counters, handshake registers and the running-sum accumulator.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      count_r    <= '0;
      idx_r      <= '0;
      ready_r    <= 1'b0;
      last_r     <= 1'b0;
      size_r     <= '0;
      overflow_r <= 1'b0;
      done_r     <= 16'd0;
      sum_r      <= '0;
    end else begin
      case (state_r)
        ST_REQUEST: begin
          if (wr_en_s) count_r <= count_r + CW'(1);
          if (ovf_s)   overflow_r <= 1'b1;
        end
        ST_PREP: begin
          ready_r <= 1'b1;
          idx_r   <= '0;
          last_r  <= (count_r == CW'(1));
          size_r  <= bytes_s[PACKET_SIZE_WIDTH-1:0];
          sum_r   <= '0;
        end
        ST_ANSWER: begin
          if (accept_s) begin
            if (last_r) begin
              ready_r <= 1'b0;
              last_r  <= 1'b0;
              size_r  <= '0;
              count_r <= '0;
              idx_r   <= '0;
              done_r  <= done_r + 16'd1;
            end else begin
              idx_r  <= idx_r + CW'(1);
              last_r <= ((idx_r + CW'(2)) == count_r);
              sum_r  <= sum_r + rd_data_s;
            end
          end
        end
        default: begin
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign o_task_data_request                = request_s;
  assign o_task_answer_ready                = ready_r;
  assign o_task_answer_data                 = answer_data_s;
  assign o_task_answer_data_last            = last_r;
  assign o_task_answer_packet_size_in_bytes = size_r;
  assign o_overflow                         = overflow_r;
  assign o_packets_done                     = done_r;

endmodule

// File: doc/task_packet_engine.md
TASK_PACKET_ENGINE -- requirements
Module: task_packet_engine

Interface
REQ-001 Parameter DATA_W, default 32, sets the input and answer word width; it SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 16, sets the maximum number of words buffered per packet; it SHALL be at least 2.
REQ-003 Parameter MODE, default 0, selects the transform: 0 pass, 1 byte-reverse each word, 2 reverse word order, 3 running sum.
REQ-004 Parameter PACKET_SIZE_WIDTH, default 8, sets the byte-count width; it SHALL be at least clog2(DEPTH*DATA_W/8+1).
REQ-005 Port i_clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-006 Port i_rst, input, 1 bit: reset, synchronous and active-low.
REQ-007 Port o_task_data_request, output, 1 bit: the engine is ready to capture input words.
REQ-008 Port i_task_data_valid, input, 1 bit: i_task_data is valid this cycle.
REQ-009 Port i_task_data, input, DATA_W bits: input word.
REQ-010 Port i_task_data_last, input, 1 bit: this word is the final word of the input packet.
REQ-011 Port o_task_answer_ready, output, 1 bit: an answer word is presented.
REQ-012 Port o_task_answer_data, output, DATA_W bits: answer word.
REQ-013 Port o_task_answer_data_last, output, 1 bit: the presented word is the final answer word.
REQ-014 Port o_task_answer_packet_size_in_bytes, output, PACKET_SIZE_WIDTH bits: answer length in bytes.
REQ-015 Port i_task_answer_accept, input, 1 bit: the consumer takes the presented word.
REQ-016 Port o_overflow, output, 1 bit: sticky flag, set when an input packet exceeds DEPTH words.
REQ-017 Port o_packets_done, output, 16 bits: count of completed answer packets.

Function
REQ-018 States SHALL be REQUEST, PREP and ANSWER.
REQ-019 o_task_data_request SHALL be 1 exactly when the state is REQUEST.
REQ-020 In REQUEST, each cycle with valid=1 SHALL store one word at the next index, starting at 0.
REQ-021 Words arriving while request=0 SHALL be ignored.
REQ-022 Valid&last in REQUEST SHALL move the state to PREP, so request is 0 on the next cycle.
REQ-023 Words arriving after DEPTH words have been stored and before last SHALL be discarded, and o_overflow SHALL be set.
REQ-024 When overflow truncates a packet, the packet length SHALL be DEPTH words.
REQ-025 PREP SHALL last exactly one cycle, so o_task_answer_ready rises on the 2nd rising edge after last is captured.
REQ-026 In ANSWER, o_task_answer_ready SHALL stay 1, and data, last and size SHALL hold stable until accepted.
REQ-027 Each cycle with ready&accept SHALL advance to the next answer word on the following cycle, giving no bubbles.
REQ-028 o_task_answer_data_last SHALL be 1 only on answer word N-1, where N is the stored word count.
REQ-029 o_task_answer_packet_size_in_bytes SHALL equal N*DATA_W/8, constant for the whole of ANSWER, and 0 outside ANSWER.
REQ-030 Acceptance of the last answer word SHALL return the state to REQUEST next cycle and increment o_packets_done, wrapping at 16'hFFFF to 0.
REQ-031 MODE 0 SHALL output word k = in[k].
REQ-032 MODE 1 SHALL output word k = in[k] with byte order reversed.
REQ-033 MODE 2 SHALL output word k = in[N-1-k].
REQ-034 MODE 3 SHALL output word k = sum of in[0..k], modulo 2^DATA_W.
REQ-035 o_task_answer_data SHALL be 0 whenever o_task_answer_ready is 0.

Reset
REQ-036 On a rising edge with i_rst=0, the state SHALL become REQUEST and the word count 0.
REQ-037 On the same edge, o_overflow, o_packets_done, ready, data, last and size SHALL become 0.
REQ-038 Reset mid-packet or mid-answer SHALL abandon the packet with no partial answer; request SHALL be 1 on the first cycle after reset releases.
REQ-039 Buffer contents SHALL need no reset.

Structure
REQ-040 Shared package task_pkg SHALL hold the state enum, the MODE_PASS, MODE_BYTE_REV, MODE_WORD_REV and MODE_SUM constants, and the byte-count function.
REQ-041 Storage SHALL be a sub-module task_packet_buffer: a DEPTH x DATA_W simple dual-port RAM with registered read, no reset.
REQ-042 task_packet_engine SHALL hold the FSM, counters, transform and output registers.

Verification (DATA_W=32, DEPTH=16)
REQ-043 MODE 0, input 3 words (11,22,33; last on 33), accept held 1 -> answer 11,22,33, last on 33, size 12, ready rising 2 cycles after last.
REQ-044 MODE 1, input 1 word 0x01020304 with last -> answer 0x04030201, last=1, size 4.
REQ-045 MODE 2, input 1,2,3,4 with accept toggling 1,0 -> answer 4,3,2,1, each word held while accept=0, size 16.
REQ-046 MODE 3, input 0xFFFFFFFF,2,3 -> answer 0xFFFFFFFF,1,4; o_packets_done=1 afterwards.
REQ-047 MODE 0, input 20 words (last on 20th) -> 16 words out, last on word 16, size 64, o_overflow=1 and staying 1 through the next packet.
REQ-048 i_rst=0 during the 2nd answer word -> outputs 0 next cycle, request=1 after release, the next packet answers correctly.
